// File: rtl/cpu_mem_req_arbiter_pkg.sv
// Shared sizes and FSM state encoding for the CPU memory request arbiter.
package cpu_mem_req_arbiter_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int DATA_SIZE = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cpu_mem_req_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module cpu_mem_req_arbiter_rr_arb_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any_req,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic w_found;

    always_comb begin
        o_any_req   = |i_req;
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        // Scan ptr+1 .. ptr+N_REQ so the last winner has lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[idx]) begin
                w_found      = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cpu_mem_req_arbiter.sv
// Round-robin arbiter forwarding one core read/write at a time to the dispatcher memory port.
// Optional WAIT timeout with error pulse is enabled by defining REQ_TIMEOUT_EN.
module cpu_mem_req_arbiter
    import cpu_mem_req_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = ADDR_SIZE,
    parameter int DATA_W      = DATA_SIZE,
    parameter int TIMEOUT_CYC = 255,
    parameter int IDX_W       = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_rd,
    input  logic [N_REQ-1:0]        i_req_wr,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_req_ack,
    output logic [N_REQ-1:0]        o_req_err,
    output logic [DATA_W-1:0]       o_rsp_rdata,
    output logic [IDX_W-1:0]        o_grant_idx,
    output logic                    o_read_q,
    output logic                    o_write_q,
    output logic [ADDR_W-1:0]       o_addr_out,
    output logic [DATA_W-1:0]       o_data_out,
    input  logic [DATA_W-1:0]       i_data_in,
    input  logic                    i_read_dn,
    input  logic                    i_write_dn
);

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt;
    logic               r_rd_q, w_rd_q_nxt;
    logic               r_wr_q, w_wr_q_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic [N_REQ-1:0]   r_ack, w_ack_nxt;
    logic               r_mask_last, w_mask_last_nxt;

    logic [N_REQ-1:0]   w_mask_vec;
    logic [N_REQ-1:0]   w_cand;
    logic               w_any;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;

`ifdef REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_timed_out, w_timed_out_nxt;
    logic [N_REQ-1:0]   r_err, w_err_nxt;
`endif

    always_comb begin
        w_mask_vec = '0;
        if (r_mask_last) w_mask_vec[r_grant_idx] = 1'b1;
        w_cand = (i_req_rd | i_req_wr) & ~w_mask_vec;
    end

    cpu_mem_req_arbiter_rr_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb_pick (
        .i_req       (w_cand),
        .i_ptr       (r_ptr),
        .o_any_req   (w_any),
        .o_grant     (w_pick_oh),
        .o_grant_idx (w_pick_idx)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_rd_q_nxt      = r_rd_q;
        w_wr_q_nxt      = r_wr_q;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_ack_nxt       = '0;
        w_mask_last_nxt = 1'b0;
`ifdef REQ_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_timed_out_nxt = r_timed_out;
        w_err_nxt       = '0;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = ARB_WAIT;
                    w_ptr_nxt       = w_pick_idx;
                    w_grant_idx_nxt = w_pick_idx;
                    w_addr_nxt      = i_req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                    w_wdata_nxt     = i_req_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
                    // A core raising both gets its read now; the write stays pending.
                    w_rd_q_nxt      = |(i_req_rd & w_pick_oh);
                    w_wr_q_nxt      = ~(|(i_req_rd & w_pick_oh));
`ifdef REQ_TIMEOUT_EN
                    w_cnt_nxt       = '0;
                    w_timed_out_nxt = 1'b0;
`endif
                end
            end
            ARB_WAIT: begin
                if (r_rd_q && i_read_dn) begin
                    w_rdata_nxt = i_data_in;
                    w_rd_q_nxt  = 1'b0;
                    w_state_nxt = ARB_RESP;
                end else if (r_wr_q && i_write_dn) begin
                    w_wr_q_nxt  = 1'b0;
                    w_state_nxt = ARB_RESP;
                end
`ifdef REQ_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rd_q_nxt      = 1'b0;
                    w_wr_q_nxt      = 1'b0;
                    w_rdata_nxt     = '0;
                    w_timed_out_nxt = 1'b1;
                    w_state_nxt     = ARB_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            ARB_RESP: begin
                w_ack_nxt[r_grant_idx] = 1'b1;
`ifdef REQ_TIMEOUT_EN
                w_err_nxt[r_grant_idx] = r_timed_out;
`endif
                w_mask_last_nxt = 1'b1;
                w_state_nxt     = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= IDX_W'(N_REQ - 1);
            r_grant_idx <= '0;
            r_rd_q      <= 1'b0;
            r_wr_q      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ack       <= '0;
            r_mask_last <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_err       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_rd_q      <= w_rd_q_nxt;
            r_wr_q      <= w_wr_q_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ack       <= w_ack_nxt;
            r_mask_last <= w_mask_last_nxt;
`ifdef REQ_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign o_req_ack   = r_ack;
    assign o_rsp_rdata = r_rdata;
    assign o_grant_idx = r_grant_idx;
    assign o_read_q    = r_rd_q;
    assign o_write_q   = r_wr_q;
    assign o_addr_out  = r_addr;
    assign o_data_out  = r_wdata;
`ifdef REQ_TIMEOUT_EN
    assign o_req_err   = r_err;
`else
    assign o_req_err   = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_req_arbiter.sv
// Directed bench for cpu_mem_req_arbiter; timeout steps are built only with REQ_TIMEOUT_EN.
module tb_cpu_mem_req_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req_rd = '0;
    logic [N_REQ-1:0]        req_wr = '0;
    logic [N_REQ*ADDR_W-1:0] req_addr = '0;
    logic [N_REQ*DATA_W-1:0] req_wdata = '0;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        req_err;
    logic [DATA_W-1:0]       rsp_rdata;
    logic [0:0]              grant_idx;
    logic                    read_q;
    logic                    write_q;
    logic [ADDR_W-1:0]       addr_out;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in = '0;
    logic                    read_dn = 1'b0;
    logic                    write_dn = 1'b0;

    int checks   = 0;
    int failures = 0;

    cpu_mem_req_arbiter #(
        .N_REQ       (N_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_rd    (req_rd),
        .i_req_wr    (req_wr),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_req_ack   (req_ack),
        .o_req_err   (req_err),
        .o_rsp_rdata (rsp_rdata),
        .o_grant_idx (grant_idx),
        .o_read_q    (read_q),
        .o_write_q   (write_q),
        .o_addr_out  (addr_out),
        .o_data_out  (data_out),
        .i_data_in   (data_in),
        .i_read_dn   (read_dn),
        .i_write_dn  (write_dn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ack", 32'(req_ack), 32'h0);
        check("rst_rdq", 32'(read_q), 32'h0);
        check("rst_wrq", 32'(write_q), 32'h0);
        check("rst_grant", 32'(grant_idx), 32'h0);
        check("rst_addr", addr_out, 32'h0);
        rst = 1'b0;

        // 1: single core0 read, done two cycles after grant
        req_rd = 2'b01;
        req_addr[0 +: 32] = 32'h10;
        tick();
        check("t1_rdq", 32'(read_q), 32'h1);
        check("t1_addr", addr_out, 32'h10);
        check("t1_grant", 32'(grant_idx), 32'h0);
        tick();
        check("t1_wait_ack", 32'(req_ack), 32'h0);
        check("t1_wait_rdq", 32'(read_q), 32'h1);
        read_dn = 1'b1;
        data_in = 32'hCAFE0001;
        tick();
        read_dn = 1'b0;
        check("t1_rdq_drop", 32'(read_q), 32'h0);
        check("t1_resp_ack", 32'(req_ack), 32'h0);
        tick();
        check("t1_ack", 32'(req_ack), 32'h1);
        check("t1_err", 32'(req_err), 32'h0);
        check("t1_rdata", rsp_rdata, 32'hCAFE0001);
        req_rd = 2'b00;
        tick();
        check("t1_ack_once", 32'(req_ack), 32'h0);

        // 2: both cores hold reads with instant dones, from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_rd = 2'b11;
        req_addr[32 +: 32] = 32'h14;
        read_dn = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("t2_grant%0d", t), 32'(grant_idx), 32'(t % 2));
            check($sformatf("t2_rdq%0d", t), 32'(read_q), 32'h1);
            tick();
            check($sformatf("t2_noack%0d", t), 32'(req_ack), 32'h0);
            tick();
            check($sformatf("t2_ack%0d", t), 32'(req_ack), 32'(1 << (t % 2)));
        end
        req_rd = 2'b00;
        read_dn = 1'b0;
        tick();

        // 3: core1 write, wrong-kind done ignored
        req_wr = 2'b10;
        req_addr[32 +: 32] = 32'h20;
        req_wdata[32 +: 32] = 32'hDEAD;
        read_dn = 1'b1;
        tick();
        check("t3_grant", 32'(grant_idx), 32'h1);
        check("t3_addr", addr_out, 32'h20);
        check("t3_rdq", 32'(read_q), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_wrq_hold%0d", i), 32'(write_q), 32'h1);
            check($sformatf("t3_noack%0d", i), 32'(req_ack), 32'h0);
            check($sformatf("t3_data%0d", i), data_out, 32'hDEAD);
        end
        read_dn = 1'b0;
        write_dn = 1'b1;
        tick();
        write_dn = 1'b0;
        check("t3_wrq_drop", 32'(write_q), 32'h0);
        tick();
        check("t3_ack", 32'(req_ack), 32'h2);
        check("t3_data_end", data_out, 32'hDEAD);
        req_wr = 2'b00;
        tick();

        // 4: core0 rd+wr together: read first, masked cycle, then write
        req_rd = 2'b01;
        req_wr = 2'b01;
        req_addr[0 +: 32] = 32'h40;
        req_wdata[0 +: 32] = 32'h1234;
        tick();
        check("t4_rd_first", 32'(read_q), 32'h1);
        check("t4_wr_not", 32'(write_q), 32'h0);
        read_dn = 1'b1;
        data_in = 32'h55;
        tick();
        read_dn = 1'b0;
        tick();
        check("t4_ack_rd", 32'(req_ack), 32'h1);
        tick();
        check("t4_masked_rdq", 32'(read_q), 32'h0);
        check("t4_masked_wrq", 32'(write_q), 32'h0);
        req_rd = 2'b00;
        tick();
        check("t4_wr_grant", 32'(write_q), 32'h1);
        check("t4_wr_gidx", 32'(grant_idx), 32'h0);
        check("t4_wr_data", data_out, 32'h1234);
        write_dn = 1'b1;
        tick();
        write_dn = 1'b0;
        tick();
        check("t4_ack_wr", 32'(req_ack), 32'h1);
        req_wr = 2'b00;
        tick();

        // 5: reset during WAIT
        req_rd = 2'b10;
        req_addr[32 +: 32] = 32'h30;
        tick();
        check("t5_grant", 32'(grant_idx), 32'h1);
        check("t5_rdq", 32'(read_q), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_drop", 32'(read_q), 32'h0);
        tick();
        check("t5_no_ack", 32'(req_ack), 32'h0);
        rst = 1'b0;
        req_rd = 2'b11;
        tick();
        check("t5_ptr_core0", 32'(grant_idx), 32'h0);
        check("t5_ack_after", 32'(req_ack), 32'h0);
        read_dn = 1'b1;
        data_in = 32'h77;
        tick();
        read_dn = 1'b0;
        req_rd = 2'b00;
        tick();
        check("t5_ack", 32'(req_ack), 32'h1);
        check("t5_rdata", rsp_rdata, 32'h77);
        tick();

`ifdef REQ_TIMEOUT_EN
        // 6: timeout after 8 WAIT cycles; then a done on the 8th cycle wins
        req_rd = 2'b01;
        tick();
        check("t6_rdq", 32'(read_q), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t6_noack%0d", i), 32'(req_ack), 32'h0);
        end
        check("t6_q_drop", 32'(read_q), 32'h0);
        tick();
        check("t6_ack", 32'(req_ack), 32'h1);
        check("t6_err", 32'(req_err), 32'h1);
        check("t6_rdata0", rsp_rdata, 32'h0);
        req_rd = 2'b00;
        tick();
        check("t6_err_once", 32'(req_err), 32'h0);
        req_rd = 2'b01;
        tick();
        for (int i = 1; i <= 7; i++) tick();
        read_dn = 1'b1;
        data_in = 32'hAB;
        tick();
        read_dn = 1'b0;
        tick();
        check("t6_late_ack", 32'(req_ack), 32'h1);
        check("t6_late_noerr", 32'(req_err), 32'h0);
        check("t6_late_rdata", rsp_rdata, 32'hAB);
        req_rd = 2'b00;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
